// File: rtl/pb_irq_pkg.sv
// Shared definitions for the Picoblaze interrupt controller: FSM state
// encoding and the source-ID width helper.
package pb_irq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2,
    ST_GAP     = 2'd3
  } irq_state_t;

  // Width of a source ID. Never narrower than one bit, even for a single source.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pb_irq_prio_enc.sv
// Combinational lowest-index-wins priority encoder. id is 0 when no request is set.
module pb_irq_prio_enc #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) id = W'(i);
    end
  end

endmodule

// File: rtl/pb_irq_controller.sv
// N-source interrupt controller for a KCPSM3 core: input synchronisers,
// per-source level/edge pending bits with write-1-to-clear, fixed priority,
// and the interrupt/interrupt_ack handshake FSM.
module pb_irq_controller
  import pb_irq_pkg::*;
#(
  parameter int          NUM_SRC     = 8,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_MASK  = 32'h0,
  localparam int         ID_W        = id_width(NUM_SRC)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] int_src,
  input  logic [NUM_SRC-1:0] int_mask,
  input  logic [NUM_SRC-1:0] int_mode,
  input  logic [NUM_SRC-1:0] int_clear,
  output logic [NUM_SRC-1:0] interrupts,
  output logic               active_valid_o,
  output logic [ID_W-1:0]    active_id_o,
  output logic [ID_W-1:0]    serviced_id_o,
  output logic               in_service_o,
  output logic               int_o,
  input  logic               int_ack_i
);

  // A reset mask naming sources that do not exist is a register-file
  // configuration error; catch it together with out-of-range sizes.
  if (NUM_SRC < 1 || NUM_SRC > 32 || SYNC_STAGES < 0 || SYNC_STAGES > 3 ||
      (RESET_MASK >> NUM_SRC) != 32'h0) begin : g_bad_param
    $error("pb_irq_controller: illegal parameter combination");
  end

  logic [NUM_SRC-1:0] s;
  logic [NUM_SRC-1:0] prev;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] masked;

  irq_state_t         state_q;
  irq_state_t         state_d;
  logic               capture;
  logic [ID_W-1:0]    serviced_q;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = int_src;
  end else begin : g_sync
    logic [NUM_SRC-1:0] chain [SYNC_STAGES];

    // Synchroniser chain into the clk_i domain.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int k = 0; k < SYNC_STAGES; k++) chain[k] <= '0;
      end else begin
        chain[0] <= int_src;
        for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
      end
    end

    assign s = chain[SYNC_STAGES-1];
  end

  // prev resets to 0, so a source already high at reset release reads as a rise.
  assign rise = s & ~prev;

  // Edge history and pending bits; in edge mode a new rise beats a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev    <= '0;
      pending <= '0;
    end else begin
      prev    <= s;
      pending <= (int_mode & (rise | (pending & ~int_clear))) | (~int_mode & s);
    end
  end

  assign interrupts = pending;
  assign masked     = pending & int_mask;

  pb_irq_prio_enc #(
    .N (NUM_SRC),
    .W (ID_W)
  ) u_prio (
    .req   (masked),
    .valid (active_valid_o),
    .id    (active_id_o)
  );

  // Handshake next-state logic; capture latches the ID the CPU acknowledged.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (active_valid_o) state_d = ST_ASSERT;
      end
      ST_ASSERT: begin
        if (int_ack_i) begin
          state_d = ST_SERVICE;
          capture = 1'b1;
        end else if (!active_valid_o) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (!masked[serviced_q]) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state and serviced-ID registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      serviced_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) serviced_q <= active_id_o;
    end
  end

  assign serviced_id_o = serviced_q;
  assign int_o         = (state_q == ST_ASSERT);
  assign in_service_o  = (state_q == ST_SERVICE);

endmodule

// File: tb/tb_pb_irq_controller.sv
// Bench for pb_irq_controller (NUM_SRC=8, SYNC_STAGES=2): directed scenarios
// with literal expectations, then randomized traffic compared every cycle
// against a behavioural model.
module tb_pb_irq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] int_src, int_mask, int_mode, int_clear;
  logic [7:0] interrupts;
  logic       active_valid;
  logic [2:0] active_id, serviced_id;
  logic       in_service, int_o, int_ack;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  pb_irq_controller #(
    .NUM_SRC     (8),
    .SYNC_STAGES (2),
    .RESET_MASK  (32'h0)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .int_src        (int_src),
    .int_mask       (int_mask),
    .int_mode       (int_mode),
    .int_clear      (int_clear),
    .interrupts     (interrupts),
    .active_valid_o (active_valid),
    .active_id_o    (active_id),
    .serviced_id_o  (serviced_id),
    .in_service_o   (in_service),
    .int_o          (int_o),
    .int_ack_i      (int_ack)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Behavioural model: a two-deep delay line of raw inputs, the last seen
  // synchronised value, the pending set, and the handshake phase.
  localparam int PH_IDLE = 0, PH_ASSERT = 1, PH_SERVICE = 2, PH_GAP = 3;
  logic [7:0] h0 = 0, h1 = 0, m_prev = 0, m_pend = 0;
  int         m_phase = PH_IDLE;
  int         m_sid = 0;

  always @(posedge clk) begin
    logic [7:0] seen, rose, req, np;
    if (rst) begin
      h0 = 0; h1 = 0; m_prev = 0; m_pend = 0; m_phase = PH_IDLE; m_sid = 0;
    end else begin
      seen = h1;
      rose = seen & ~m_prev;
      req  = m_pend & int_mask;
      for (int i = 0; i < 8; i++) begin
        if (int_mode[i]) begin
          if (rose[i])           np[i] = 1'b1;
          else if (int_clear[i]) np[i] = 1'b0;
          else                   np[i] = m_pend[i];
        end else begin
          np[i] = seen[i];
        end
      end
      case (m_phase)
        PH_IDLE:    if (req != 0) m_phase = PH_ASSERT;
        PH_ASSERT:  if (int_ack) begin m_phase = PH_SERVICE; m_sid = lowest(req); end
                    else if (req == 0) m_phase = PH_IDLE;
        PH_SERVICE: if (!req[m_sid]) m_phase = PH_GAP;
        default:    m_phase = PH_IDLE;
      endcase
      m_pend = np;
      m_prev = seen;
      h1 = h0;
      h0 = int_src;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("interrupts",   {24'h0, interrupts},        {24'h0, m_pend});
      chk("active_valid", {31'h0, active_valid},      {31'h0, |(m_pend & int_mask)});
      chk("active_id",    {29'h0, active_id},         lowest(m_pend & int_mask));
      chk("serviced_id",  {29'h0, serviced_id},       m_sid);
      chk("in_service",   {31'h0, in_service},        {31'h0, m_phase == PH_SERVICE});
      chk("int_o",        {31'h0, int_o},             {31'h0, m_phase == PH_ASSERT});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; int_src = 0; int_mask = 0; int_mode = 0; int_clear = 0; int_ack = 0;
    repeat (3) step();
    chk_en = 1;
    chk("rst_int_o", {31'h0, int_o}, 0);
    chk("rst_interrupts", {24'h0, interrupts}, 0);
    chk("rst_serviced", {29'h0, serviced_id}, 0);
    chk("rst_in_service", {31'h0, in_service}, 0);
    rst = 0;

    // Edge source 2: latency, ack, clear, gap.
    int_mode = 8'hFF; int_mask = 8'h04; int_src = 8'h04;
    step(); int_src = 0;
    step(); step();
    chk("t1_lat3", {31'h0, int_o}, 0);
    step();
    chk("t1_lat4", {31'h0, int_o}, 1);
    chk("t1_id", {29'h0, active_id}, 2);
    int_ack = 1; step(); int_ack = 0;
    chk("t1_ack_int", {31'h0, int_o}, 0);
    chk("t1_sid", {29'h0, serviced_id}, 2);
    chk("t1_svc", {31'h0, in_service}, 1);
    int_clear = 8'h04; step(); int_clear = 0;
    chk("t1_clr", {24'h0, interrupts}, 0);
    step();
    chk("t1_gap", {31'h0, in_service | int_o}, 0);
    step();

    // Priority: sources 5 and 1 together.
    int_mask = 8'hFF; int_src = 8'h22;
    step(); int_src = 0;
    repeat (3) step();
    chk("t2_int", {31'h0, int_o}, 1);
    chk("t2_id1", {29'h0, active_id}, 1);
    int_ack = 1; step(); int_ack = 0;
    int_clear = 8'h02; step(); int_clear = 0;
    step();
    chk("t2_gap", {31'h0, int_o}, 0);
    step(); step();
    chk("t2_reassert", {31'h0, int_o}, 1);
    chk("t2_id5", {29'h0, active_id}, 5);
    int_ack = 1; step(); int_ack = 0;
    int_clear = 8'h20; step(); int_clear = 0;
    step(); step();

    // Level source 0: clear ignored, drop ends service.
    int_mode = 8'h00; int_mask = 8'h01; int_src = 8'h01;
    repeat (4) step();
    chk("t3_int", {31'h0, int_o}, 1);
    int_ack = 1; step(); int_ack = 0;
    int_clear = 8'h01; step(); int_clear = 0;
    chk("t3_clr_ignored", {24'h0, interrupts}, 8'h01);
    int_src = 0;
    step(); step();
    chk("t3_still", {24'h0, interrupts}, 8'h01);
    step();
    chk("t3_drop", {24'h0, interrupts}, 0);
    step();
    chk("t3_left_svc", {31'h0, in_service}, 0);
    step();

    // Withdrawn level request, no ack.
    int_mask = 8'h08; int_src = 8'h08;
    repeat (5) step();
    chk("t4_int", {31'h0, int_o}, 1);
    int_src = 0;
    repeat (5) step();
    chk("t4_withdrawn", {31'h0, int_o | in_service}, 0);

    // Set/clear collision and masked capture.
    int_mode = 8'hFF; int_mask = 8'h00; int_src = 8'h10;
    step(); int_src = 0;
    step();
    int_clear = 8'h10; step(); int_clear = 0;
    chk("t5_set_wins", {24'h0, interrupts}, 8'h10);
    repeat (3) step();
    chk("t5_masked", {31'h0, int_o}, 0);
    int_mask = 8'h10; #1;
    chk("t5_valid", {31'h0, active_valid}, 1);
    step();
    chk("t5_unmask", {31'h0, int_o}, 1);
    int_ack = 1; step(); int_ack = 0;
    int_clear = 8'h10; step(); int_clear = 0;
    step(); step();

    // Reset during ASSERT with source 7 held high.
    int_mask = 8'h80; int_src = 8'h80;
    repeat (4) step();
    chk("t6_int", {31'h0, int_o}, 1);
    rst = 1; step(); rst = 0;
    chk("t6_rst_int", {31'h0, int_o}, 0);
    chk("t6_rst_pend", {24'h0, interrupts}, 0);
    int_ack = 1; step(); int_ack = 0;
    step(); step();
    chk("t6_lat3", {31'h0, int_o}, 0);
    step();
    chk("t6_lat4", {31'h0, int_o}, 1);
    int_src = 0;
    int_ack = 1; step(); int_ack = 0;
    int_clear = 8'h80; step(); int_clear = 0;
    step(); step();

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int_src   = 8'($urandom);
      if ($urandom_range(0, 15) == 0) int_mask = 8'($urandom);
      if ($urandom_range(0, 63) == 0) int_mode = 8'($urandom);
      int_clear = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      int_ack   = ($urandom_range(0, 4) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0; int_ack = 0; int_clear = 0;
    step();
    chk_en = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
